// File: rtl/machine_mode_types_pkg.sv
// Shared machine-mode types: claim FSM encoding and interrupt controller defaults.
package machine_mode_types_pkg;

  localparam int NUM_SRC_DEFAULT = 8;
  localparam int PRIO_W_DEFAULT  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } claim_state_e;

endpackage

// File: rtl/prv_intr_ctrl_if.sv
// Claim/complete handshake between the CSR block (master) and the interrupt controller (slave).
interface prv_intr_ctrl_if #(
  parameter int NUM_SRC = machine_mode_types_pkg::NUM_SRC_DEFAULT
);
  localparam int ID_W = $clog2(NUM_SRC + 1);

  logic            claim_req;
  logic            claim_ready;
  logic            claim_valid;
  logic [ID_W-1:0] claim_id;
  logic            complete_req;
  logic [ID_W-1:0] complete_id;

  modport master (
    output claim_req, complete_req, complete_id,
    input  claim_ready, claim_valid, claim_id
  );

  modport slave (
    input  claim_req, complete_req, complete_id,
    output claim_ready, claim_valid, claim_id
  );
endinterface

// File: rtl/prv_intr_gateway.sv
// Per-source gateway tracking pending/inflight; edge capture with a one-deep deferred
// slot is built only when INTR_EDGE_DETECT_EN is defined.
module prv_intr_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
`ifdef INTR_EDGE_DETECT_EN
  input  logic edge_mode,
`endif
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pending
);
  logic pending_reg, pending_next;
  logic inflight_reg, inflight_next;
  logic retire;

  // Completion only counts for a source that is actually being serviced.
  assign retire = complete_hit & inflight_reg;

`ifdef INTR_EDGE_DETECT_EN
  logic irq_prev_reg;
  logic deferred_reg, deferred_next;
  logic rise, busy, set_pend, defer_set;

  assign rise      = irq & ~irq_prev_reg;
  assign busy      = pending_reg | inflight_reg;
  assign set_pend  = edge_mode ? (rise & ~busy) : (irq & ~inflight_reg);
  assign defer_set = edge_mode & rise & busy;

  assign deferred_next = retire ? defer_set : (deferred_reg | defer_set);
  assign pending_next  = ~claim_hit & (pending_reg | set_pend | (retire & deferred_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_reg <= 1'b0;
      deferred_reg <= 1'b0;
    end else begin
      irq_prev_reg <= irq;
      deferred_reg <= deferred_next;
    end
  end
`else
  assign pending_next = ~claim_hit & (pending_reg | (irq & ~inflight_reg));
`endif

  // Complete is applied before claim, so a same-edge claim leaves the source inflight.
  assign inflight_next = claim_hit | (inflight_reg & ~retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= 1'b0;
      inflight_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      inflight_reg <= inflight_next;
    end
  end

  assign pending = pending_reg;
endmodule

// File: rtl/prv_intr_ctrl.sv
// Platform interrupt controller: per-source gateways, registered priority arbiter and
// claim/complete FSM. Edge-triggered sources are enabled by defining INTR_EDGE_DETECT_EN.
module prv_intr_ctrl
  import machine_mode_types_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int PRIO_W  = PRIO_W_DEFAULT
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_SRC-1:0]        src_irq,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
  input  logic [PRIO_W-1:0]         threshold,
  input  logic [NUM_SRC-1:0]        edge_mode,
  output logic                      ext_int,
  prv_intr_ctrl_if.slave            bus
);
  localparam int ID_W   = $clog2(NUM_SRC + 1);
  localparam int LEAVES = 1 << $clog2(NUM_SRC);
  localparam int NODES  = 2 * LEAVES - 1;

  claim_state_e      state_reg;
  logic [ID_W-1:0]   best_id_reg;
  logic              best_vld_reg;
  logic [ID_W-1:0]   claim_id_reg;
  logic              claim_valid_reg;
  logic              claim_take;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] claim_hit;
  logic [NUM_SRC-1:0] complete_hit;
  logic [PRIO_W-1:0]  leaf_prio [NUM_SRC];

  logic              t_vld  [NODES];
  logic [PRIO_W-1:0] t_prio [NODES];
  logic [ID_W-1:0]   t_id   [NODES];

  assign claim_take = (state_reg == IDLE) & bus.claim_req;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign leaf_prio[gi]    = src_prio[gi*PRIO_W +: PRIO_W];
    assign eligible[gi]     = pending[gi] & src_en[gi] & (leaf_prio[gi] > threshold);
    assign claim_hit[gi]    = claim_take & (best_id_reg == ID_W'(gi + 1));
    assign complete_hit[gi] = bus.complete_req & (bus.complete_id == ID_W'(gi + 1));

    prv_intr_gateway u_gw (
      .clk          (CLK),
      .rst_n        (nRST),
      .irq          (src_irq[gi]),
`ifdef INTR_EDGE_DETECT_EN
      .edge_mode    (edge_mode[gi]),
`endif
      .claim_hit    (claim_hit[gi]),
      .complete_hit (complete_hit[gi]),
      .pending      (pending[gi])
    );
  end

`ifndef INTR_EDGE_DETECT_EN
  logic unused_edge_mode;
  assign unused_edge_mode = ^edge_mode;
`endif

  // Heap-ordered binary tree: the left child always covers lower IDs, so the right
  // child only wins on a strictly higher priority, which gives lowest-ID tie-breaking.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      t_vld[n]  = 1'b0;
      t_prio[n] = '0;
      t_id[n]   = '0;
    end
    for (int n = 0; n < NUM_SRC; n++) begin
      t_vld[LEAVES-1+n]  = eligible[n];
      t_prio[LEAVES-1+n] = leaf_prio[n];
      t_id[LEAVES-1+n]   = ID_W'(n + 1);
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      if (t_vld[2*n+2] && (!t_vld[2*n+1] || (t_prio[2*n+2] > t_prio[2*n+1]))) begin
        t_vld[n]  = 1'b1;
        t_prio[n] = t_prio[2*n+2];
        t_id[n]   = t_id[2*n+2];
      end else begin
        t_vld[n]  = t_vld[2*n+1];
        t_prio[n] = t_prio[2*n+1];
        t_id[n]   = t_id[2*n+1];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      best_vld_reg    <= 1'b0;
      best_id_reg     <= '0;
      state_reg       <= IDLE;
      claim_valid_reg <= 1'b0;
      claim_id_reg    <= '0;
    end else begin
      best_vld_reg <= t_vld[0];
      best_id_reg  <= t_vld[0] ? t_id[0] : '0;
      case (state_reg)
        IDLE: begin
          if (bus.claim_req) begin
            state_reg       <= RESP;
            claim_valid_reg <= 1'b1;
            claim_id_reg    <= best_id_reg;
          end
        end
        RESP: begin
          state_reg       <= IDLE;
          claim_valid_reg <= 1'b0;
        end
        default: begin
          state_reg       <= IDLE;
          claim_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ext_int         = best_vld_reg;
  assign bus.claim_ready = (state_reg == IDLE);
  assign bus.claim_valid = claim_valid_reg;
  assign bus.claim_id    = claim_id_reg;
endmodule

// File: tb/tb_prv_intr_ctrl.sv
// Bench for prv_intr_ctrl: directed scenarios with literal expectations plus a randomized
// run, all compared every cycle against a behavioural model of pending/inflight/claim rules.
module tb_prv_intr_ctrl;
  localparam int NS = 8;
  localparam int PW = 3;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic [NS-1:0]     src_irq = '0;
  logic [NS-1:0]     src_en = '0;
  logic [NS-1:0]     edge_mode = '0;
  logic [NS*PW-1:0]  src_prio = '0;
  logic [PW-1:0]     threshold = '0;
  logic              ext_int;

  prv_intr_ctrl_if #(.NUM_SRC(NS)) bus ();

  prv_intr_ctrl #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .src_irq   (src_irq),
    .src_en    (src_en),
    .src_prio  (src_prio),
    .threshold (threshold),
    .edge_mode (edge_mode),
    .ext_int   (ext_int),
    .bus       (bus)
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend [NS];
  bit m_infl [NS];
`ifdef INTR_EDGE_DETECT_EN
  bit m_defr [NS];
  bit m_prev [NS];
`endif
  int m_best_id  = 0;
  bit m_resp     = 0;
  int m_claim_id = 0;

  function automatic int prio_of(input int i);
    return int'(src_prio[i*PW +: PW]);
  endfunction

  // Highest priority above threshold among enabled pending sources; lowest ID on a tie.
  function automatic int m_arbitrate();
    int best = 0;
    int bp = -1;
    for (int i = 0; i < NS; i++)
      if (m_pend[i] && src_en[i] && prio_of(i) > int'(threshold) && prio_of(i) > bp) begin
        bp = prio_of(i);
        best = i + 1;
      end
    return best;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = 0;
      m_infl[i] = 0;
`ifdef INTR_EDGE_DETECT_EN
      m_defr[i] = 0;
      m_prev[i] = 0;
`endif
    end
    m_best_id = 0;
    m_resp = 0;
    m_claim_id = 0;
  endtask

  task automatic m_step();
    int nb;
    int cid;
    bit o_pend [NS];
    bit o_infl [NS];
    nb = m_arbitrate();
    o_pend = m_pend;
    o_infl = m_infl;
    cid = int'(bus.complete_id);
    if (bus.complete_req && cid >= 1 && cid <= NS && o_infl[cid-1]) begin
      m_infl[cid-1] = 0;
`ifdef INTR_EDGE_DETECT_EN
      if (m_defr[cid-1]) begin
        m_pend[cid-1] = 1;
        m_defr[cid-1] = 0;
      end
`endif
    end
    for (int i = 0; i < NS; i++) begin
`ifdef INTR_EDGE_DETECT_EN
      if (edge_mode[i]) begin
        if (src_irq[i] && !m_prev[i]) begin
          if (o_pend[i] || o_infl[i]) m_defr[i] = 1;
          else m_pend[i] = 1;
        end
      end else if (src_irq[i] && !o_infl[i]) m_pend[i] = 1;
      m_prev[i] = src_irq[i];
`else
      if (src_irq[i] && !o_infl[i]) m_pend[i] = 1;
`endif
    end
    if (!m_resp && bus.claim_req) begin
      m_resp = 1;
      m_claim_id = m_best_id;
      if (m_best_id != 0) begin
        m_pend[m_best_id-1] = 0;
        m_infl[m_best_id-1] = 1;
      end
    end else begin
      m_resp = 0;
    end
    m_best_id = nb;
  endtask

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) m_reset();
    else m_step();
  end

  always @(negedge CLK) begin
    check("ext_int", int'(ext_int), int'(m_best_id != 0));
    check("claim_valid", int'(bus.claim_valid), int'(m_resp));
    check("claim_id", int'(bus.claim_id), m_claim_id);
    check("claim_ready", int'(bus.claim_ready), int'(!m_resp));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic set_prio(input int id, input int p);
    src_prio[(id-1)*PW +: PW] = PW'(p);
  endtask

  task automatic do_claim(output int id);
    bus.claim_req = 1'b1;
    tick(1);
    check("claim_pulse", int'(bus.claim_valid), 1);
    id = int'(bus.claim_id);
    bus.claim_req = 1'b0;
    tick(1);
    $display("claim transaction: id=%0d at %0t", id, $time);
  endtask

  task automatic do_complete(input int id);
    bus.complete_req = 1'b1;
    bus.complete_id  = 4'(id);
    tick(1);
    bus.complete_req = 1'b0;
    $display("complete transaction: id=%0d at %0t", id, $time);
  endtask

  task automatic hold_reset();
    nRST = 1'b0;
    src_irq = '0;
    src_en = '0;
    src_prio = '0;
    threshold = '0;
    edge_mode = '0;
    bus.claim_req = 1'b0;
    bus.complete_req = 1'b0;
    tick(2);
  endtask

  initial begin
    int id;
    int cand [$];
    bus.claim_req = 1'b0;
    bus.complete_req = 1'b0;
    bus.complete_id = '0;

    // Reset held while every line toggles: nothing may escape.
    nRST = 1'b0;
    src_en = '1;
    src_irq = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("rst_ext_int", int'(ext_int), 0);
      check("rst_claim_valid", int'(bus.claim_valid), 0);
      check("rst_claim_id", int'(bus.claim_id), 0);
      src_irq = ~src_irq;
    end

    // Priority pick: src 2 prio 3, src 5 prio 6, threshold 2.
    hold_reset();
    src_en = '1;
    set_prio(2, 3);
    set_prio(5, 6);
    threshold = 3'd2;
    src_irq = 8'h12;
    nRST = 1'b1;
    tick(1);
    check("prio_ext_int_early", int'(ext_int), 0);
    tick(1);
    check("prio_ext_int", int'(ext_int), 1);
    bus.claim_req = 1'b1;
    tick(1);
    check("prio_claim_valid", int'(bus.claim_valid), 1);
    check("prio_claim_id", int'(bus.claim_id), 5);
    check("prio_claim_ready", int'(bus.claim_ready), 0);
    tick(1);
    check("resp_ignores_claim", int'(bus.claim_valid), 0);
    check("resp_back_idle", int'(bus.claim_ready), 1);
    $display("claim transaction: id=%0d at %0t", 5, $time);
    bus.claim_req = 1'b0;
    do_complete(7);
    do_complete(5);
    tick(2);
    // Claim and complete of source 5 on the same edge.
    bus.claim_req = 1'b1;
    bus.complete_req = 1'b1;
    bus.complete_id = 4'd5;
    tick(1);
    check("same_cycle_claim_id", int'(bus.claim_id), 5);
    bus.claim_req = 1'b0;
    bus.complete_req = 1'b0;
    tick(4);
    do_claim(id);
    check("src5_still_inflight", id, 2);

    // Tie and threshold: srcs 1 and 4 at prio 4.
    hold_reset();
    src_en = '1;
    set_prio(1, 4);
    set_prio(4, 4);
    threshold = 3'd4;
    src_irq = 8'h09;
    nRST = 1'b1;
    tick(3);
    check("thr_equal_blocks", int'(ext_int), 0);
    threshold = 3'd3;
    tick(1);
    check("thr_lower_fires", int'(ext_int), 1);
    do_claim(id);
    check("tie_lowest_id", id, 1);

    // Reset in the middle of a claim response aborts it.
    tick(2);
    bus.claim_req = 1'b1;
    tick(1);
    check("abort_pre_valid", int'(bus.claim_valid), 1);
    nRST = 1'b0;
    bus.claim_req = 1'b0;
    #1;
    check("abort_valid", int'(bus.claim_valid), 0);
    check("abort_ext_int", int'(ext_int), 0);
    tick(1);
    nRST = 1'b1;
    tick(2);
    check("abort_no_pulse", int'(bus.claim_valid), 0);

`ifdef INTR_EDGE_DETECT_EN
    // Edge source 3: deferred slot captures one extra edge while inflight.
    hold_reset();
    src_en = '1;
    set_prio(3, 5);
    edge_mode = 8'h04;
    nRST = 1'b1;
    src_irq[2] = 1'b1;
    tick(1);
    src_irq[2] = 1'b0;
    tick(2);
    do_claim(id);
    check("edge_claim1", id, 3);
    for (int k = 0; k < 2; k++) begin
      src_irq[2] = 1'b1;
      tick(1);
      src_irq[2] = 1'b0;
      tick(1);
    end
    do_complete(3);
    tick(2);
    do_claim(id);
    check("edge_claim2", id, 3);
    do_complete(3);
    tick(2);
    do_claim(id);
    check("edge_claim3", id, 0);
`endif

    // Randomized traffic against the model.
    hold_reset();
    nRST = 1'b1;
    src_en = NS'($urandom);
    src_prio = (NS*PW)'($urandom);
    threshold = PW'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 7) == 0) src_irq[i] = ~src_irq[i];
      if ($urandom_range(0, 31) == 0) src_en = NS'($urandom);
      if ($urandom_range(0, 63) == 0) src_prio = (NS*PW)'($urandom);
      if ($urandom_range(0, 63) == 0) threshold = PW'($urandom_range(0, 7));
      if ($urandom_range(0, 127) == 0) edge_mode = NS'($urandom);
      bus.claim_req = ($urandom_range(0, 3) == 0);
      bus.complete_req = ($urandom_range(0, 2) == 0);
      cand.delete();
      for (int i = 0; i < NS; i++) if (m_infl[i]) cand.push_back(i + 1);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1)
        bus.complete_id = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        bus.complete_id = 4'($urandom_range(0, 15));
      if (cyc % 500 == 499) begin
        nRST = 1'b0;
        tick(1);
        nRST = 1'b1;
      end
      tick(1);
    end
    bus.claim_req = 1'b0;
    bus.complete_req = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
